m_pool_ctrl: RTL and testbench
==============================

# m_pool_ctrl

Sequencer for the max/ReLU pooling stage. It walks a conv-output feature-map RAM in pooling-window order and streams one sample per cycle into the pooling unit. It holds the pooling unit cleared between frames and turns the unit's `wr` pulses into addressed writes for the pooled-map RAM. It sits between the conv-layer output buffer and the next layer's input buffer and exposes a `start`/`busy`/`done` handshake to the top-level layer scheduler.

## Interface
Parameters:
- `MAP_W`, default 88: input map width in samples.
- `MAP_H`, default 88: input map height in samples.
- `WIN`, default 4: pooling window side. The pooling unit must be built with `max_stride = WIN*WIN-1`.
- `CH`, default 1: number of channel maps stored back-to-back in the input RAM.
- `ADDR_W`, default 13: read address width. Must satisfy 2^ADDR_W ≥ CH*MAP_W*MAP_H.
- `OADDR_W`, default 9: write address width. Must satisfy 2^OADDR_W ≥ CH*(MAP_W/WIN)*(MAP_H/WIN).

Ports:
- `clk_in`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: frame start request. Sampled only in IDLE.
- `rd_en`, output, 1: input-RAM read strobe. RAM data is valid at the pooling unit 1 cycle later.
- `rd_addr`, output, ADDR_W: input-RAM read address.
- `pool_hold`, output, 1: drives the pooling unit's clear/hold input (active high).
- `pool_wr`, input, 1: the pooling unit's output strobe.
- `wr_en`, output, 1: output-RAM write strobe.
- `wr_addr`, output, OADDR_W: output-RAM write address.
- `busy`, output, 1: high from the cycle after `start` is accepted until `done`.
- `done`, output, 1: one-cycle pulse when the last pooled word is written.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- **IDLE**:
  - Outputs: `rd_en`=0, `pool_hold`=1, `busy`=0.
  - When `start`=1, clear all counters and go to READ.
- **READ**:
  - `rd_en`=1 every cycle, no gaps, in this loop order (outer to inner): channel c, output row oy, output column ox, window row ky, window column kx.
  - `rd_addr` = c·MAP_W·MAP_H + (oy·WIN+ky)·MAP_W + ox·WIN + kx.
  - Addresses are computed incrementally with base registers. No multipliers.
  - After the read with c=CH-1, oy=ox=ky=kx at their maxima, go to DRAIN.
- **DRAIN**:
  - `rd_en`=0.
  - Wait until the output count reaches TOTAL = CH·(MAP_W/WIN)·(MAP_H/WIN), then go to DONE.
- **DONE**:
  - `done`=1 for exactly one cycle, `busy`=0, `pool_hold`=1.
  - Go to IDLE.
- **`pool_hold`**: registered copy of `rd_en`, inverted. It is low exactly on the cycles when valid RAM data is present at the pooling input. This keeps the unit's stride counter aligned to window boundaries.
- **Output write path**:
  - On `pool_wr`=1 while `busy`, set `wr_en`=1 combinationally with `wr_addr` = current out_cnt. out_cnt increments at that clock edge.
  - Output order is row-major per channel, channels consecutive.
- **Ignored inputs**: `pool_wr` outside `busy` is ignored (no write, no count). `start` while `busy` is ignored.
- **Back-to-back frames**: `start` held high during DONE is not accepted until IDLE. This guarantees at least 2 hold cycles between frames.
- **Reset**: asserting `rst_n`=0 mid-frame immediately forces IDLE and all outputs to reset values. Partially written output is abandoned.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `pool_hold`=1, `wr_en`=0, `wr_addr`=0, `busy`=0, `done`=0.
- `start` sampled at edge T → first `rd_en`=1 with `rd_addr`=0 in cycle T+1. `busy`=1 from T+1.
- Read cycle R → data at the pooling input in cycle R+1, with `pool_hold`=0 in R+1.
- The pooling unit emits `pool_wr` in the cycle after the last sample of a window.
- READ lasts exactly CH·MAP_W·MAP_H cycles.
- Last read at cycle L → last `pool_wr` at L+2 → `done` at L+3.
- Total frame latency, `start` edge to `done`: CH·MAP_W·MAP_H + 3 cycles.
- `wr_en` is never asserted in two consecutive cycles unless WIN=1. WIN=1 is unsupported; WIN ≥ 2 is required.

## Test plan
- **Params 8/8/2/2, ADDR_W=7, OADDR_W=5**:
  - Pulse `start` → first rd_addr sequence is 0,1,8,9,2,3,10,11,4,5,12,13,6,7,14,15,16,17,24,25.
  - Channel 1 begins at address 64.
  - 128 reads, no gaps.
- **Same config, with a behavioural pooling model**:
  - Expect 32 `wr_en` pulses, `wr_addr` 0..31 in order.
  - `done` one cycle, 131 cycles after the `start` edge.
  - `busy` falls with `done`.
- **Hold alignment**: feed RAM values = address.
  - Expect pooled outputs 9,11,13,15,25,… for channel 0 and 73,… for channel 1.
  - `pool_hold`=0 only on data-valid cycles.
- **Spurious inputs**:
  - `start` pulsed at cycles 5 and 40 of a frame → ignored, address sequence unchanged.
  - `pool_wr` forced high in IDLE → no `wr_en`.
- **Reset mid-frame**:
  - Assert `rst_n`=0 asynchronously at read 50 → same-cycle `rd_en`=0, `pool_hold`=1, `busy`=0.
  - Release and restart → addresses restart at 0.
- **Default params 88/88/4/1**:
  - 7744 reads, 484 writes, last `wr_addr`=483.
  - `done` 7747 cycles after `start`.

Source files
------------

// File: rtl/m_pool_ctrl.sv
// m_pool_ctrl: sequencer for the max/ReLU pooling stage.
//
// Walks a conv-output feature-map RAM in pooling-window order (channel,
// output row, output column, window row, window column) and issues one read
// per cycle. The pooling unit is held cleared except on cycles where valid
// RAM data sits at its input. The unit's write strobes become addressed writes
// into the pooled-map RAM.
//
// Ports:
//   clk_in    in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   frame start request, sampled only in IDLE
//   rd_en     out  input-RAM read strobe (data valid one cycle later)
//   rd_addr   out  input-RAM read address [ADDR_W]
//   pool_hold out  pooling unit clear/hold (active high)
//   pool_wr   in   pooling unit output strobe
//   wr_en     out  output-RAM write strobe
//   wr_addr   out  output-RAM write address [OADDR_W]
//   busy      out  frame in progress
//   done      out  one-cycle pulse when the frame is complete
module m_pool_ctrl #(
  parameter int MAP_W   = 88,
  parameter int MAP_H   = 88,
  parameter int WIN     = 4,
  parameter int CH      = 1,
  parameter int ADDR_W  = 13,
  parameter int OADDR_W = 9
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               pool_hold,
  input  logic               pool_wr,
  output logic               wr_en,
  output logic [OADDR_W-1:0] wr_addr,
  output logic               busy,
  output logic               done
);

  localparam int OW    = MAP_W / WIN;
  localparam int OH    = MAP_H / WIN;
  localparam int TOTAL = CH * OW * OH;
  localparam int KW    = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int OXW   = (OW > 1) ? $clog2(OW) : 1;
  localparam int OYW   = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  // One extra bit so TOTAL is representable even when it equals 2^OADDR_W.
  localparam int CNT_W = OADDR_W + 1;

  localparam logic [ADDR_W-1:0] STEP_WIN = ADDR_W'(WIN);
  localparam logic [ADDR_W-1:0] STEP_ROW = ADDR_W'(MAP_W);
  localparam logic [ADDR_W-1:0] STEP_BLK = ADDR_W'(WIN * MAP_W);
  localparam logic [ADDR_W-1:0] STEP_CH  = ADDR_W'(MAP_W * MAP_H);
  localparam logic [KW-1:0]     K_MAX    = KW'(WIN - 1);
  localparam logic [OXW-1:0]    OX_MAX   = OXW'(OW - 1);
  localparam logic [OYW-1:0]    OY_MAX   = OYW'(OH - 1);
  localparam logic [CW-1:0]     C_MAX    = CW'(CH - 1);
  localparam logic [CNT_W-1:0]  TOTAL_C  = CNT_W'(TOTAL);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q,   state_d;
  logic [KW-1:0]      kx_q,      kx_d;
  logic [KW-1:0]      ky_q,      ky_d;
  logic [OXW-1:0]     ox_q,      ox_d;
  logic [OYW-1:0]     oy_q,      oy_d;
  logic [CW-1:0]      c_q,       c_d;
  // Base registers: channel start, window-row block start, window top-left,
  // current window line start, and the live read address.
  logic [ADDR_W-1:0]  ch_base_q, ch_base_d;
  logic [ADDR_W-1:0]  blk_q,     blk_d;
  logic [ADDR_W-1:0]  win_q,     win_d;
  logic [ADDR_W-1:0]  line_q,    line_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               hold_q;
  logic               clr_walk;

  assign rd_en     = (state_q == S_READ);
  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pool_hold = hold_q;
  assign rd_addr   = addr_q;
  assign wr_en     = pool_wr & busy;
  assign wr_addr   = out_cnt_q[OADDR_W-1:0];

  always_comb begin
    state_d   = state_q;
    kx_d      = kx_q;
    ky_d      = ky_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    c_d       = c_q;
    ch_base_d = ch_base_q;
    blk_d     = blk_q;
    win_d     = win_q;
    line_d    = line_q;
    addr_d    = addr_q;
    out_cnt_d = out_cnt_q;
    clr_walk  = 1'b0;

    if (wr_en) out_cnt_d = out_cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_READ;
          clr_walk  = 1'b1;
          out_cnt_d = '0;
        end
      end
      S_READ: begin
        // Innermost loop that has not wrapped advances; everything inside it
        // restarts from the next outer base.
        if (kx_q != K_MAX) begin
          kx_d   = kx_q + KW'(1);
          addr_d = addr_q + ADDR_W'(1);
        end else if (ky_q != K_MAX) begin
          kx_d   = '0;
          ky_d   = ky_q + KW'(1);
          line_d = line_q + STEP_ROW;
          addr_d = line_q + STEP_ROW;
        end else if (ox_q != OX_MAX) begin
          kx_d   = '0;
          ky_d   = '0;
          ox_d   = ox_q + OXW'(1);
          win_d  = win_q + STEP_WIN;
          line_d = win_q + STEP_WIN;
          addr_d = win_q + STEP_WIN;
        end else if (oy_q != OY_MAX) begin
          kx_d   = '0;
          ky_d   = '0;
          ox_d   = '0;
          oy_d   = oy_q + OYW'(1);
          blk_d  = blk_q + STEP_BLK;
          win_d  = blk_q + STEP_BLK;
          line_d = blk_q + STEP_BLK;
          addr_d = blk_q + STEP_BLK;
        end else if (c_q != C_MAX) begin
          kx_d      = '0;
          ky_d      = '0;
          ox_d      = '0;
          oy_d      = '0;
          c_d       = c_q + CW'(1);
          ch_base_d = ch_base_q + STEP_CH;
          blk_d     = ch_base_q + STEP_CH;
          win_d     = ch_base_q + STEP_CH;
          line_d    = ch_base_q + STEP_CH;
          addr_d    = ch_base_q + STEP_CH;
        end else begin
          state_d  = S_DRAIN;
          clr_walk = 1'b1;
        end
      end
      S_DRAIN: begin
        // Look at the post-increment count so DONE follows the last write.
        if (out_cnt_d == TOTAL_C) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (clr_walk) begin
      kx_d      = '0;
      ky_d      = '0;
      ox_d      = '0;
      oy_d      = '0;
      c_d       = '0;
      ch_base_d = '0;
      blk_d     = '0;
      win_d     = '0;
      line_d    = '0;
      addr_d    = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kx_q      <= '0;
      ky_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      c_q       <= '0;
      ch_base_q <= '0;
      blk_q     <= '0;
      win_q     <= '0;
      line_q    <= '0;
      addr_q    <= '0;
      out_cnt_q <= '0;
      hold_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      kx_q      <= kx_d;
      ky_q      <= ky_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      c_q       <= c_d;
      ch_base_q <= ch_base_d;
      blk_q     <= blk_d;
      win_q     <= win_d;
      line_q    <= line_d;
      addr_q    <= addr_d;
      out_cnt_q <= out_cnt_d;
      // Data read in cycle R is at the pooling input in R+1; release hold then.
      hold_q    <= ~rd_en;
    end
  end

endmodule

// File: tb/tb_m_pool_ctrl.sv
`timescale 1ns/1ps
module tb_m_pool_ctrl;

  typedef struct {
    int idx;
    int exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // Instance A: 8x8 map, 2x2 window, 2 channels
  logic       start_a = 1'b0;
  logic       pool_wr_a;
  logic       rd_en_a;
  logic [6:0] rd_addr_a;
  logic       pool_hold_a;
  logic       wr_en_a;
  logic [4:0] wr_addr_a;
  logic       busy_a;
  logic       done_a;

  // Instance B: default parameters
  logic        start_b = 1'b0;
  logic        pool_wr_b;
  logic        rd_en_b;
  logic [12:0] rd_addr_b;
  logic        pool_hold_b;
  logic        wr_en_b;
  logic [8:0]  wr_addr_b;
  logic        busy_b;
  logic        done_b;

  m_pool_ctrl #(.MAP_W(8), .MAP_H(8), .WIN(2), .CH(2), .ADDR_W(7), .OADDR_W(5)) dut_a (
    .clk_in(clk), .rst_n(rst_n), .start(start_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .pool_hold(pool_hold_a), .pool_wr(pool_wr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .busy(busy_a), .done(done_a)
  );

  m_pool_ctrl dut_b (
    .clk_in(clk), .rst_n(rst_n), .start(start_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .pool_hold(pool_hold_b), .pool_wr(pool_wr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .busy(busy_b), .done(done_b)
  );

  // RAMs with one-cycle read latency and behavioural max-pooling units
  localparam int WA = 2;
  localparam int WB = 4;
  int ram_a [128];
  int ram_b [8192];
  int dat_a = 0, acc_a = 0, cnt_a = 0, res_a = 0;
  int dat_b = 0, acc_b = 0, cnt_b = 0, res_b = 0;
  logic pw_a = 1'b0, pw_b = 1'b0, force_wr = 1'b0;

  always @(posedge clk) begin
    dat_a <= ram_a[rd_addr_a];
    if (pool_hold_a) begin
      cnt_a <= 0; pw_a <= 1'b0;
    end else if (cnt_a == WA*WA-1) begin
      pw_a <= 1'b1; res_a <= (dat_a > acc_a) ? dat_a : acc_a; cnt_a <= 0;
    end else begin
      pw_a <= 1'b0; acc_a <= (cnt_a == 0 || dat_a > acc_a) ? dat_a : acc_a; cnt_a <= cnt_a + 1;
    end
  end

  always @(posedge clk) begin
    dat_b <= ram_b[rd_addr_b];
    if (pool_hold_b) begin
      cnt_b <= 0; pw_b <= 1'b0;
    end else if (cnt_b == WB*WB-1) begin
      pw_b <= 1'b1; res_b <= (dat_b > acc_b) ? dat_b : acc_b; cnt_b <= 0;
    end else begin
      pw_b <= 1'b0; acc_b <= (cnt_b == 0 || dat_b > acc_b) ? dat_b : acc_b; cnt_b <= cnt_b + 1;
    end
  end

  assign pool_wr_a = pw_a | force_wr;
  assign pool_wr_b = pw_b;

  // Monitor mux so one frame task serves either instance
  logic sel_b = 1'b0;
  logic m_rd_en, m_hold, m_wr_en, m_busy, m_done;
  int   m_rd_addr, m_wr_addr, m_res;
  always_comb begin
    m_rd_en   = sel_b ? rd_en_b     : rd_en_a;
    m_hold    = sel_b ? pool_hold_b : pool_hold_a;
    m_wr_en   = sel_b ? wr_en_b     : wr_en_a;
    m_busy    = sel_b ? busy_b      : busy_a;
    m_done    = sel_b ? done_b      : done_a;
    m_rd_addr = sel_b ? int'(rd_addr_b) : int'(rd_addr_a);
    m_wr_addr = sel_b ? int'(wr_addr_b) : int'(wr_addr_a);
    m_res     = sel_b ? res_b : res_a;
  end

  int checks = 0;
  int errors = 0;
  int ref_rd[$], ref_max[$], got_rd[$], got_wa[$], got_wd[$];
  int rd_first, rd_last, done_cyc, hold_bad, busy_bad, sp1, sp2;
  logic done_busy;

  int first20 [20] = '{0, 1, 8, 9, 2, 3, 10, 11, 4, 5, 12, 13, 6, 7, 14, 15, 16, 17, 24, 25};
  vec_t addr_tab [22];
  vec_t res_tab [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel_b) start_b = v;
    else start_a = v;
  endtask

  // Reference: plain nested loops over the window order, address by formula.
  task automatic build_ref(input int mw, input int mh, input int win, input int ch, input bit use_b);
    ref_rd.delete();
    ref_max.delete();
    for (int c = 0; c < ch; c++)
      for (int oy = 0; oy < mh/win; oy++)
        for (int ox = 0; ox < mw/win; ox++) begin
          int m;
          m = -1;
          for (int ky = 0; ky < win; ky++)
            for (int kx = 0; kx < win; kx++) begin
              int a, v;
              a = c*mw*mh + (oy*win + ky)*mw + ox*win + kx;
              ref_rd.push_back(a);
              v = use_b ? ram_b[a] : ram_a[a];
              if (v > m) m = v;
            end
          ref_max.push_back(m);
        end
  endtask

  // mode 0: plain, 1: spurious start pulses at sp1/sp2, 2: reset after 50 reads,
  // 3: start held high throughout
  task automatic frame(input int mode, input int max_cyc);
    logic prev_rd;
    got_rd.delete(); got_wa.delete(); got_wd.delete();
    rd_first = -1; rd_last = -1; done_cyc = -1; hold_bad = 0; busy_bad = 0;
    done_busy = 1'b1; prev_rd = 1'b0;
    @(negedge clk); set_start(1'b1);
    @(negedge clk);
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (m_hold !== !prev_rd) hold_bad++;
      if (!m_done && m_busy !== 1'b1) busy_bad++;
      if (m_rd_en) begin
        got_rd.push_back(m_rd_addr);
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
      end
      if (m_wr_en) begin
        got_wa.push_back(m_wr_addr);
        got_wd.push_back(m_res);
      end
      if (m_done) begin
        done_cyc = cyc; done_busy = m_busy;
        break;
      end
      if (mode == 2 && got_rd.size() == 50) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid.rd_en", m_rd_en, 0);
        chk("rst_mid.pool_hold", m_hold, 1);
        chk("rst_mid.busy", m_busy, 0);
        chk("rst_mid.rd_addr", m_rd_addr, 0);
        chk("rst_mid.wr_en", m_wr_en, 0);
        break;
      end
      set_start((mode == 3) || (mode == 1 && (cyc == sp1 || cyc == sp2)));
      prev_rd = m_rd_en;
      @(negedge clk);
    end
    if (mode != 3) set_start(1'b0);
  endtask

  task automatic check_frame(input string tag, input int n_rd, input int n_wr, input int lat);
    int bad;
    chk({tag, ".reads"}, got_rd.size(), n_rd);
    bad = 0;
    for (int i = 0; i < got_rd.size() && i < ref_rd.size(); i++)
      if (got_rd[i] != ref_rd[i]) bad++;
    chk({tag, ".rd_seq_bad"}, bad, 0);
    chk({tag, ".rd_first"}, rd_first, 1);
    chk({tag, ".rd_span"}, rd_last - rd_first + 1, n_rd);
    chk({tag, ".writes"}, got_wa.size(), n_wr);
    bad = 0;
    for (int i = 0; i < got_wa.size(); i++) if (got_wa[i] != i) bad++;
    chk({tag, ".wr_addr_bad"}, bad, 0);
    bad = 0;
    for (int i = 0; i < got_wd.size() && i < ref_max.size(); i++)
      if (got_wd[i] != ref_max[i]) bad++;
    chk({tag, ".wr_data_bad"}, bad, 0);
    chk({tag, ".done_cyc"}, done_cyc, lat);
    chk({tag, ".busy_at_done"}, done_busy, 0);
    chk({tag, ".hold_bad"}, hold_bad, 0);
    chk({tag, ".busy_bad"}, busy_bad, 0);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, ".done_pulse"}, m_done, 0);
    chk({tag, ".idle_busy"}, m_busy, 0);
  endtask

  initial begin
    int wa_before, k, got;
    logic bad_wr;

    for (int i = 0; i < 20; i++) addr_tab[i] = '{i, first20[i]};
    addr_tab[20] = '{64, 64};
    addr_tab[21] = '{127, 127};
    res_tab[0] = '{0, 9};  res_tab[1] = '{1, 11}; res_tab[2] = '{2, 13};
    res_tab[3] = '{3, 15}; res_tab[4] = '{4, 25}; res_tab[5] = '{16, 73};
    res_tab[6] = '{31, 127};
    for (int i = 0; i < 128; i++) ram_a[i] = i;
    for (int i = 0; i < 8192; i++) ram_b[i] = int'($urandom_range(0, 65535));

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst.rd_en", rd_en_a, 0);
    chk("rst.rd_addr", rd_addr_a, 0);
    chk("rst.pool_hold", pool_hold_a, 1);
    chk("rst.wr_en", wr_en_a, 0);
    chk("rst.wr_addr", wr_addr_a, 0);
    chk("rst.busy", busy_a, 0);
    chk("rst.done", done_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // pool_wr in IDLE must neither write nor count
    wa_before = int'(wr_addr_a);
    force_wr = 1'b1;
    bad_wr = 1'b0;
    repeat (4) begin
      #1; if (wr_en_a) bad_wr = 1'b1;
      @(negedge clk);
    end
    force_wr = 1'b0;
    chk("idle_wr.wr_en", bad_wr, 0);
    chk("idle_wr.wr_addr", wr_addr_a, wa_before);

    // Frame with RAM = address, table-driven spot checks
    build_ref(8, 8, 2, 2, 1'b0);
    frame(0, 400);
    check_frame("A0", 128, 32, 131);
    after_done("A0");
    for (int i = 0; i < 22; i++) begin
      got = (addr_tab[i].idx < got_rd.size()) ? got_rd[addr_tab[i].idx] : -1;
      chk($sformatf("tab.rd_addr[%0d]", addr_tab[i].idx), got, addr_tab[i].exp);
    end
    for (int i = 0; i < 7; i++) begin
      got = (res_tab[i].idx < got_wd.size()) ? got_wd[res_tab[i].idx] : -1;
      chk($sformatf("tab.pooled[%0d]", res_tab[i].idx), got, res_tab[i].exp);
    end

    // Random RAM contents with spurious start pulses
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 128; i++) ram_a[i] = int'($urandom_range(0, 1000));
      sp1 = (f == 0) ? 5 : int'($urandom_range(2, 125));
      sp2 = (f == 0) ? 40 : int'($urandom_range(2, 125));
      build_ref(8, 8, 2, 2, 1'b0);
      frame(1, 400);
      check_frame($sformatf("Arnd%0d", f), 128, 32, 131);
      after_done($sformatf("Arnd%0d", f));
    end

    // Reset mid-frame, then restart from address 0
    frame(2, 400);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    build_ref(8, 8, 2, 2, 1'b0);
    frame(0, 400);
    check_frame("Arst", 128, 32, 131);
    after_done("Arst");

    // start held through DONE: accepted only from IDLE
    frame(3, 400);
    chk("b2b.done_cyc", done_cyc, 131);
    @(negedge clk);
    chk("b2b.idle_busy", busy_a, 0);
    chk("b2b.idle_rd_en", rd_en_a, 0);
    chk("b2b.idle_hold", pool_hold_a, 1);
    @(negedge clk);
    chk("b2b.restart_rd_en", rd_en_a, 1);
    chk("b2b.restart_addr", rd_addr_a, 0);
    chk("b2b.restart_busy", busy_a, 1);
    start_a = 1'b0;
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (done_a) begin k = i; break; end
    end
    chk("b2b.second_lat", k, 130);

    // Default parameters
    sel_b = 1'b1;
    build_ref(88, 88, 4, 1, 1'b1);
    frame(0, 8000);
    check_frame("B", 7744, 484, 7747);
    chk("B.last_wr_addr", (got_wa.size() > 0) ? got_wa[got_wa.size()-1] : -1, 483);
    after_done("B");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
